// File: rtl/painterengine_gpu_dma_burst_reader_if.sv
// AXI4 read-address and read-data channels between the burst reader (master)
// and the memory system (slave).
interface painterengine_gpu_dma_burst_reader_if #(
  parameter int P_DATA_WIDTH = 32
);
  logic                    arid;
  logic [31:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic                    rid;
  logic [P_DATA_WIDTH-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/painterengine_gpu_dma_burst_reader.sv
// AXI4 burst reader: splits one channel's transfer into 4 KB / max-burst safe
// INCR bursts and streams the returned beats to the selected consumer.
module painterengine_gpu_dma_burst_reader #(
  parameter int P_CHANNELS     = 4,
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_MAX_BURST    = 256,
  parameter int P_TIMEOUT_BITS = 19
) (
  input  logic                               i_wire_clock,
  input  logic                               i_wire_resetn,
  input  logic                               i_wire_start,
  input  logic [P_CHANNELS-1:0]              i_wire_router,
  input  logic [P_CHANNELS*32-1:0]           i_wire_address,
  input  logic [P_CHANNELS*32-1:0]           i_wire_length,
  output logic [P_CHANNELS*P_DATA_WIDTH-1:0] o_wire_data,
  output logic [P_CHANNELS-1:0]              o_wire_data_valid,
  output logic [P_CHANNELS-1:0]              o_wire_data_last,
  input  logic [P_CHANNELS-1:0]              i_wire_data_next,
  output logic                               o_wire_busy,
  output logic                               o_wire_done,
  output logic                               o_wire_error,
  output logic [2:0]                         o_wire_error_type,
  painterengine_gpu_dma_burst_reader_if.master axi
);

  localparam int BYTES  = P_DATA_WIDTH / 8;
  localparam int SIZE_W = $clog2(BYTES);
  localparam int SEL_W  = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_DONE, S_ERROR
  } state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [31:0]               address_q, address_d;
  logic [31:0]               length_q, length_d;
  logic [31:0]               offset_q, offset_d;
  logic [31:0]               cur_addr_q, cur_addr_d;
  logic [8:0]                burst_q, burst_d;
  logic [8:0]                beat_q, beat_d;
  logic [P_TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [2:0]                error_type_q, error_type_d;

  logic [SEL_W-1:0] start_sel;
  logic             router_onehot;
  logic [63:0]      end_addr;
  logic             misaligned;
  logic [31:0]      calc_addr;
  logic [31:0]      remaining;
  logic [12:0]      to_4k;
  logic [8:0]       to_max;
  logic [8:0]       calc_burst;
  logic [8:0]       burst_m1;
  logic             beat_ok;
  logic             last_beat;
  logic             final_burst;

  always_comb begin
    start_sel = '0;
    for (int i = 0; i < P_CHANNELS; i++) begin
      if (i_wire_router[i]) start_sel = SEL_W'(i);
    end
  end

  assign router_onehot = $onehot(i_wire_router);
  assign end_addr      = {32'd0, address_q} + ({32'd0, length_q} << SIZE_W);
  assign misaligned    = |address_q[SIZE_W-1:0];

  // Burst length is the tightest of: beats left, beats to the 4 KB page end,
  // and beats to the next P_MAX_BURST-aligned beat index.
  assign calc_addr = address_q + (offset_q << SIZE_W);
  assign remaining = length_q - offset_q;
  assign to_4k     = (13'h1000 - {1'b0, calc_addr[11:0]}) >> SIZE_W;
  assign to_max    = 9'(P_MAX_BURST) - {1'b0, calc_addr[SIZE_W +: 8] & 8'(P_MAX_BURST - 1)};

  always_comb begin
    calc_burst = to_max;
    if ({4'd0, calc_burst} > to_4k) calc_burst = to_4k[8:0];
    if ({23'd0, calc_burst} > remaining) calc_burst = remaining[8:0];
  end

  assign burst_m1    = burst_q - 9'd1;
  assign beat_ok     = (state_q == S_DATA) && axi.rvalid && i_wire_data_next[sel_q];
  assign last_beat   = (beat_q == burst_m1);
  assign final_burst = ((offset_q + {23'd0, burst_q}) == length_q);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    address_d    = address_q;
    length_d     = length_q;
    offset_d     = offset_q;
    cur_addr_d   = cur_addr_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    wd_d         = '0;
    error_type_d = error_type_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_wire_start) begin
          sel_d        = start_sel;
          address_d    = i_wire_address[start_sel*32 +: 32];
          length_d     = i_wire_length[start_sel*32 +: 32];
          offset_d     = '0;
          error_type_d = 3'd0;
          if (router_onehot) begin
            state_d = S_CHECK;
          end else begin
            state_d      = S_ERROR;
            error_type_d = 3'd1;
          end
        end
      end
      S_CHECK: begin
        if (misaligned || (length_q == 32'd0) || (end_addr > 64'h1_0000_0000)) begin
          state_d      = S_ERROR;
          error_type_d = 3'd2;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cur_addr_d = calc_addr;
        burst_d    = calc_burst;
        state_d    = S_ADDR;
      end
      S_ADDR: begin
        if (axi.arready) begin
          beat_d  = '0;
          state_d = S_DATA;
        end else if (wd_q[P_TIMEOUT_BITS-1]) begin
          state_d      = S_ERROR;
          error_type_d = 3'd3;
        end else begin
          wd_d = wd_q + P_TIMEOUT_BITS'(1);
        end
      end
      S_DATA: begin
        if (beat_ok) begin
          if (axi.rresp != 2'b00) begin
            state_d      = S_ERROR;
            error_type_d = 3'd6;
          end else if (last_beat != axi.rlast) begin
            state_d      = S_ERROR;
            error_type_d = 3'd5;
          end else if (last_beat) begin
            offset_d = offset_q + {23'd0, burst_q};
            state_d  = final_burst ? S_DONE : S_CALC;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end else if (wd_q[P_TIMEOUT_BITS-1]) begin
          state_d      = S_ERROR;
          error_type_d = 3'd4;
        end else begin
          wd_d = wd_q + P_TIMEOUT_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      address_q    <= '0;
      length_q     <= '0;
      offset_q     <= '0;
      cur_addr_q   <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      error_type_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      address_q    <= address_d;
      length_q     <= length_d;
      offset_q     <= offset_d;
      cur_addr_q   <= cur_addr_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      error_type_q <= error_type_d;
    end
  end

  // Consumer routing is combinational off the state register, so reset clears it at once.
  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    o_wire_data_last  = '0;
    axi.rready        = 1'b0;
    if (state_q == S_DATA) begin
      o_wire_data[sel_q*P_DATA_WIDTH +: P_DATA_WIDTH] = axi.rdata;
      o_wire_data_valid[sel_q] = axi.rvalid;
      o_wire_data_last[sel_q]  = axi.rvalid && last_beat && final_burst;
      axi.rready               = i_wire_data_next[sel_q];
    end
  end

  assign axi.arid    = 1'b0;
  assign axi.araddr  = cur_addr_q;
  assign axi.arlen   = burst_m1[7:0];
  assign axi.arsize  = 3'(SIZE_W);
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0010;
  assign axi.arprot  = 3'd0;
  assign axi.arqos   = 4'd0;
  assign axi.arvalid = (state_q == S_ADDR);

  assign o_wire_busy       = state_q inside {S_CHECK, S_CALC, S_ADDR, S_DATA};
  assign o_wire_done       = (state_q == S_DONE);
  assign o_wire_error      = (state_q == S_ERROR);
  assign o_wire_error_type = error_type_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_burst_reader.sv
// Self-checking bench: a memory slave model plus a transfer-level reference
// (burst list and beat stream) derived from the address/length rules.
module tb_painterengine_gpu_dma_burst_reader;

  localparam int CH   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 256;
  localparam int TOB  = 8;

  logic             clock;
  logic             resetn;
  logic             start;
  logic [CH-1:0]    router;
  logic [CH*32-1:0] address;
  logic [CH*32-1:0] length;
  logic [CH*DW-1:0] data;
  logic [CH-1:0]    data_valid;
  logic [CH-1:0]    data_last;
  logic [CH-1:0]    data_next;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       error_type;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];

  bit          sl_active;
  logic [31:0] sl_addr;
  int          sl_len;
  int          sl_beat;
  int          tr_beat;

  painterengine_gpu_dma_burst_reader_if #(.P_DATA_WIDTH(DW)) axi_bus ();

  painterengine_gpu_dma_burst_reader #(
    .P_CHANNELS    (CH),
    .P_DATA_WIDTH  (DW),
    .P_MAX_BURST   (MAXB),
    .P_TIMEOUT_BITS(TOB)
  ) dut (
    .i_wire_clock     (clock),
    .i_wire_resetn    (resetn),
    .i_wire_start     (start),
    .i_wire_router    (router),
    .i_wire_address   (address),
    .i_wire_length    (length),
    .o_wire_data      (data),
    .o_wire_data_valid(data_valid),
    .o_wire_data_last (data_last),
    .i_wire_data_next (data_next),
    .o_wire_busy      (busy),
    .o_wire_done      (done),
    .o_wire_error     (error),
    .o_wire_error_type(error_type),
    .axi              (axi_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // fault: 0 none, 1 early RLAST at fault_beat, 2 RRESP=2 at fault_beat,
  // 3 ARREADY stuck low, 4 RVALID stuck low, 5 RLAST missing on first burst end
  task automatic applyStimulus(input logic [3:0] rt, input logic [31:0] ad, input logic [31:0] ln,
                               input int fault, input int fault_beat, input bit rnd, input int rst_beat);
    int          exp_err;
    int          sel;
    int          cyc;
    int          budget;
    int          rx_count;
    int          ar_count;
    bit          finished;
    bit          reset_hit;
    longint      off;
    longint      cur;
    longint      b;
    logic [31:0] qa;
    int          ql;
    logic [CH*DW-1:0] slice_mask;

    if ($countones(rt) != 1) exp_err = 1;
    else if ((ad % 4 != 0) || (ln == 0) || (longint'(ad) + longint'(ln) * 4 > 64'h1_0000_0000)) exp_err = 2;
    else begin
      case (fault)
        1, 5:    exp_err = 5;
        2:       exp_err = 6;
        3:       exp_err = 3;
        4:       exp_err = 4;
        default: exp_err = 0;
      endcase
    end

    sel = 0;
    for (int c = CH - 1; c >= 0; c--) if (rt[c]) sel = c;
    slice_mask = {DW{1'b1}};
    slice_mask = slice_mask << (sel * DW);

    exp_ar_addr.delete();
    exp_ar_len.delete();
    if (exp_err != 1 && exp_err != 2) begin
      off = 0;
      while (off < longint'(ln)) begin
        cur = longint'(ad) + off * 4;
        b = longint'(ln) - off;
        if ((4096 - cur % 4096) / 4 < b) b = (4096 - cur % 4096) / 4;
        if (MAXB - (cur / 4) % MAXB < b) b = MAXB - (cur / 4) % MAXB;
        exp_ar_addr.push_back(32'(cur));
        exp_ar_len.push_back(int'(b) - 1);
        off += b;
      end
    end

    for (int c = 0; c < CH; c++) begin
      if (rt[c] || $countones(rt) != 1) begin
        address[c*32 +: 32] = ad;
        length[c*32 +: 32]  = ln;
      end else begin
        address[c*32 +: 32] = $urandom;
        length[c*32 +: 32]  = $urandom;
      end
    end
    router    = rt;
    sl_active = 1'b0;
    sl_beat   = 0;
    tr_beat   = 0;
    rx_count  = 0;
    ar_count  = 0;
    finished  = 1'b0;
    reset_hit = 1'b0;
    budget    = int'(ln % 1000) * 10 + 400;
    cyc       = 0;

    while (!finished && cyc < budget) begin
      @(negedge clock);
      start = (cyc == 0);
      axi_bus.arready = (fault == 3) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      data_next = rnd ? 4'($urandom) : 4'hF;
      if (sl_active) begin
        axi_bus.rvalid = (fault == 4) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        axi_bus.rdata  = memData(sl_addr + 32'(sl_beat) * 4);
        axi_bus.rlast  = (sl_beat == sl_len);
        if (fault == 1 && tr_beat + 1 == fault_beat) axi_bus.rlast = 1'b1;
        if (fault == 5 && sl_beat == sl_len) axi_bus.rlast = 1'b0;
        axi_bus.rresp  = (fault == 2 && tr_beat + 1 == fault_beat) ? 2'd2 : 2'd0;
      end else begin
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata  = $urandom;
        axi_bus.rlast  = 1'b0;
        axi_bus.rresp  = 2'd0;
      end
      #3;
      if (cyc == 1 && exp_err != 1) checkOutput("busy_after_start", busy, 1);
      if (axi_bus.arvalid && axi_bus.arready) begin
        ar_count++;
        if (exp_ar_addr.size() == 0) begin
          checkOutput("ar_extra", ar_count, 64'(ar_count - 1));
        end else begin
          qa = exp_ar_addr.pop_front();
          ql = exp_ar_len.pop_front();
          checkOutput("ar_addr", axi_bus.araddr, qa);
          checkOutput("ar_len", axi_bus.arlen, ql);
        end
        checkOutput("ar_const",
                    {axi_bus.arid, axi_bus.arsize, axi_bus.arburst, axi_bus.arlock,
                     axi_bus.arcache, axi_bus.arprot, axi_bus.arqos},
                    {1'b0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0});
        sl_active = 1'b1;
        sl_addr   = axi_bus.araddr;
        sl_len    = int'(axi_bus.arlen);
        sl_beat   = 0;
      end
      if (axi_bus.rvalid && axi_bus.rready) begin
        checkOutput("beat_ready", data_next[sel], 1);
        if (rx_count >= int'(ln)) begin
          checkOutput("beat_extra", rx_count, ln);
        end else begin
          checkOutput("beat_data", data[sel*DW +: DW], memData(ad + 32'(rx_count) * 4));
          checkOutput("beat_flags", {data_valid, data_last},
                      {rt, (rx_count == int'(ln) - 1) ? rt : 4'b0000});
          checkOutput("other_slices", |(data & ~slice_mask), 0);
        end
        rx_count++;
        tr_beat++;
        sl_beat++;
        if (sl_beat > sl_len) sl_active = 1'b0;
      end
      if (cyc >= 1 && (done || error)) finished = 1'b1;
      if (rst_beat > 0 && tr_beat == rst_beat && !finished) begin
        resetn = 1'b0;
        #1;
        checkOutput("reset_outputs",
                    {axi_bus.arvalid, axi_bus.rready, data_valid, data_last, busy, done, error, error_type},
                    0);
        checkOutput("reset_data", |data, 0);
        reset_hit = 1'b1;
        finished  = 1'b1;
      end
      if (!finished) cyc++;
    end

    checkOutput("finished_in_budget", finished, 1);
    if (reset_hit) begin
      @(negedge clock);
      resetn = 1'b1;
      #3;
      checkOutput("post_reset_status", {busy, done, error, error_type}, 0);
    end else begin
      checkOutput("status", {busy, done, error}, (exp_err == 0) ? 3'b010 : 3'b001);
      checkOutput("error_type", error_type, exp_err);
      if (exp_err == 0) begin
        checkOutput("beat_count", rx_count, ln);
        checkOutput("ar_left", exp_ar_addr.size(), 0);
      end
      if (exp_err == 1 || exp_err == 2) checkOutput("ar_count", ar_count, 0);
      if (exp_err == 3 || exp_err == 4)
        checkOutput("watchdog_window", (cyc >= 2 ** (TOB - 1)) && (cyc <= 2 ** (TOB - 1) + 12), 1);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rl;
    logic [3:0]  rr;

    resetn    = 1'b0;
    start     = 1'b0;
    router    = '0;
    address   = '0;
    length    = '0;
    data_next = '0;
    axi_bus.arready = 1'b0;
    axi_bus.rid     = 1'b0;
    axi_bus.rdata   = '0;
    axi_bus.rresp   = 2'd0;
    axi_bus.rlast   = 1'b0;
    axi_bus.rvalid  = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    checkOutput("reset_state",
                {axi_bus.arvalid, axi_bus.rready, data_valid, data_last, busy, done, error, error_type}, 0);
    @(negedge clock);
    resetn = 1'b1;

    $display("[TB] directed transfers");
    applyStimulus(4'b0010, 32'h0000_1000, 32'd8, 0, 0, 1'b0, 0);
    applyStimulus(4'b0001, 32'h0000_0FF0, 32'd8, 0, 0, 1'b0, 0);
    applyStimulus(4'b0100, 32'h0000_0000, 32'd300, 0, 0, 1'b0, 0);
    applyStimulus(4'b0110, 32'h0000_1000, 32'd8, 0, 0, 1'b0, 0);
    applyStimulus(4'b1000, 32'h0000_1002, 32'd8, 0, 0, 1'b0, 0);
    applyStimulus(4'b1000, 32'h0000_2000, 32'd12, 0, 0, 1'b1, 0);
    applyStimulus(4'b0001, 32'h0000_2000, 32'd0, 0, 0, 1'b0, 0);
    applyStimulus(4'b0010, 32'hFFFF_FFF0, 32'd4, 0, 0, 1'b0, 0);
    applyStimulus(4'b0010, 32'hFFFF_FFF0, 32'd5, 0, 0, 1'b0, 0);

    $display("[TB] fault injection");
    applyStimulus(4'b0010, 32'h0000_1000, 32'd8, 1, 3, 1'b0, 0);
    applyStimulus(4'b0100, 32'h0000_1000, 32'd8, 2, 2, 1'b0, 0);
    applyStimulus(4'b0001, 32'h0000_1000, 32'd8, 3, 0, 1'b0, 0);
    applyStimulus(4'b0001, 32'h0000_1000, 32'd8, 4, 0, 1'b0, 0);
    applyStimulus(4'b1000, 32'h0000_1000, 32'd8, 5, 0, 1'b0, 0);
    applyStimulus(4'b0010, 32'h0000_1000, 32'd16, 0, 0, 1'b0, 5);
    applyStimulus(4'b0010, 32'h0000_3000, 32'd16, 0, 0, 1'b0, 0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 25; n++) begin
      rr = 4'b0001 << $urandom_range(0, CH - 1);
      if ($urandom_range(0, 7) == 0) rr = 4'($urandom);
      ra = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 1) ra = ra | (32'h0000_0F00 + 32'($urandom_range(0, 63)) * 4);
      else ra = ra | (32'($urandom_range(0, 1023)) * 4);
      rl = 32'($urandom_range(1, 70));
      applyStimulus(rr, ra, rl, 0, 0, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
